// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared formats, opcodes and FIFO entry type for imm_gen_stage
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_SH = 3'd6,
    FMT_Z  = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // XLEN-independent part of a FIFO entry; the immediate lives in a parallel XLEN-wide array.
  typedef struct packed {
    logic [31:0] instr;
    fmt_e        fmt;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational opcode/funct3 to {imm, fmt, illegal} decoder
// Macro IMM_GEN_ZICSR_EN enables the Z (CSR immediate) format for opcode 1110011.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_sh;
  logic [XLEN-1:0] imm_z;

  assign opc      = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  // Only the 64-bit OP-IMM shift has a 6-bit shamt; the W-form keeps 5 bits.
  assign imm_sh = (RV64 && (opc == OPC_OPIMM)) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
  assign imm_z  = XLEN'(instr[19:15]);

  always_comb begin
    fmt     = FMT_R;
    illegal = 1'b0;
    imm     = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = imm_u;
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = imm_j;
      end
      OPC_JALR, OPC_LOAD: begin
        fmt = FMT_I;
        imm = imm_i;
      end
      OPC_OPIMM: begin
        fmt = is_shift ? FMT_SH : FMT_I;
        imm = is_shift ? imm_sh : imm_i;
      end
      OPC_OPIMM32: begin
        if (RV64) begin
          fmt = is_shift ? FMT_SH : FMT_I;
          imm = is_shift ? imm_sh : imm_i;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = imm_s;
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = imm_b;
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
      OPC_OP32: begin
        illegal = !RV64;
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
        if (funct3[2] && (funct3[1:0] != 2'b00)) begin
          fmt = FMT_Z;
          imm = imm_z;
        end else begin
          fmt = FMT_I;
          imm = imm_i;
        end
`else
        fmt = FMT_I;
        imm = imm_i;
`endif
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - buffered immediate-generation stage with flush and back-pressure
// Macro IMM_GEN_ZICSR_EN (in imm_decode) enables the Z format for CSR immediates.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  entry_t          meta_mem [BUF_DEPTH];
  logic [XLEN-1:0] imm_mem  [BUF_DEPTH];
  entry_t          head;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  // Flush wins: an input accepted by the handshake in a flush cycle is simply dropped.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      meta_mem[wr_ptr] <= '{instr: in_instr, fmt: dec_fmt, illegal: dec_illegal};
      imm_mem[wr_ptr]  <= dec_imm;
    end
  end

  assign head        = meta_mem[rd_ptr];
  assign out_instr   = out_valid ? head.instr   : '0;
  assign out_imm     = out_valid ? imm_mem[rd_ptr] : '0;
  assign out_fmt     = out_valid ? head.fmt     : 3'd0;
  assign out_illegal = out_valid ? head.illegal : 1'b0;

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Parametrised, buffered immediate-generation stage for the decode pipeline. It accepts one fetched instruction per cycle over a valid/ready handshake, classifies its format from the opcode and funct3, builds the single selected sign- or zero-extended immediate at XLEN width, and queues the result in a small FIFO toward the execute stage. It replaces the flat all-formats immediate generator with one format-resolved immediate plus a format tag, flush, and back-pressure.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- BUF_DEPTH, 2: output FIFO entries; power of two, 2..8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush; empties the FIFO.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes head entry.
- out_instr  out  32  instruction word of the head entry.
- out_imm  out  XLEN  resolved immediate.
- out_fmt  out  3  format tag: R=0, I=1, S=2, B=3, U=4, J=5, SH=6, Z=7.
- out_illegal  out  1  opcode not recognised.

## Operation
- Decode on opcode in_instr[6:0]:
  - 0110111, 0010111 -> U: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - 1101111 -> J.
  - 1100111, 0000011, 0010011 -> I.
  - 0011011 -> I only when XLEN=64; when XLEN=32 it is illegal.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110011 -> R, with imm 0. 0111011 -> R only when XLEN=64; when XLEN=32 it is illegal.
  - 1110011 -> see Configuration.
  - Any other opcode: fmt=R, imm=0, illegal=1.
- Shift immediates use format SH when opcode is 0010011 or 0011011 and funct3 is 001 or 101:
  - imm = zero-extended instr[24:20], or instr[25:20] when XLEN=64 and opcode is 0010011.
  - Upper funct7 bits are not checked.
- I, S, B, and J immediates use the standard RV field layouts. B and J have bit0=0. All are sign-extended from instr[31] to XLEN.
- A push occurs when in_valid & in_ready. The decoded {instr, imm, fmt, illegal} is written at the tail.
- A pop occurs when out_valid & out_ready.
- Simultaneous push and pop are both performed; the count is unchanged.
- in_ready = (count < BUF_DEPTH). It does not depend on out_ready, so a push into a full FIFO is impossible.
- out_valid = (count != 0). When out_valid=0, out_instr, out_imm, out_fmt, and out_illegal read 0.
- Pointers wrap modulo BUF_DEPTH. Count width is $clog2(BUF_DEPTH)+1.
- Flush has priority over push and pop. Pointers and count go to 0, and any same-cycle input is dropped. in_ready is evaluated normally during the flush cycle, but the accepted word is discarded.

## Timing
- Reset values: count=0, pointers=0, out_valid=0, in_ready=1, all data outputs 0. FIFO storage is not reset.
- Latency: a word pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1.
- Throughput is one instruction per cycle with out_ready held high for BUF_DEPTH≥2.
- Asserting rst_n low mid-operation discards all entries immediately. No entry survives reset.

## Configuration
- Macro IMM_GEN_ZICSR_EN.
- When defined, opcode 1110011 behaves as follows:
  - funct3 in {101, 110, 111}: fmt=Z, imm = zero-extended instr[19:15].
  - Any other funct3: fmt=I, imm = sign-extended I immediate.
- When undefined, opcode 1110011 always decodes as I. The Z tag is never produced.

## Structure
- Package imm_gen_pkg holds:
  - the fmt enum (3-bit);
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OP32, OPC_SYSTEM);
  - the FIFO entry struct.
- Sub-module imm_decode: purely combinational, parametrised by XLEN. It maps instr to {imm, fmt, illegal}.
- The top level holds the FIFO, handshake, and flush logic.

## Test plan
- Reset, then push 0xFFF00093 (addi x1,x0,-1) with XLEN=32. Next cycle: out_imm=0xFFFFFFFF, out_fmt=I, out_illegal=0.
- Push 0xFE000EE3 (beq, offset -4). Expected out_imm=0xFFFFFFFC, fmt=B. Push 0x00001537 (lui). Expected out_imm=0x00001000, fmt=U.
- XLEN=64: push 0x03F09093 (slli x1,x1,63). Expected out_imm=63, fmt=SH. Push 0x0000001B with XLEN=32. Expected out_illegal=1, imm=0.
- Hold out_ready=0 and push BUF_DEPTH words. in_ready drops after the last push. Release out_ready: data drains in order, one per cycle, then out_valid=0.
- Fill the FIFO to 1 entry, then assert flush with in_valid=1 in the same cycle. Next cycle: out_valid=0, count=0, and the flushed input never appears.
- With IMM_GEN_ZICSR_EN defined, push 0x3057D073 (csrrwi mtvec,15). Expected out_imm=15, fmt=Z. Without the macro, the same push gives fmt=I, imm=0x305.
